// File: rtl/mac_rx_frame_fifo_pkg.sv
// Shared beat geometry, stored-beat layout and write-FSM encoding for the
// MAC RX store-and-forward frame FIFO.
package mac_rx_frame_fifo_pkg;

  localparam int unsigned N_SYMBOLS = 8;
  localparam int unsigned W_SYMBOL  = 8;
  localparam int unsigned W_DATA    = N_SYMBOLS * W_SYMBOL;

  typedef struct packed {
    logic                 tlast;
    logic [N_SYMBOLS-1:0] tkeep;
    logic [W_DATA-1:0]    tdata;
  } axis_beat_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FRAME,
    WR_DROP
  } wr_state_e;

endpackage

// File: rtl/mac_rx_frame_fifo_ram.sv
// Simple dual-port beat store: one write port, one read port with a
// registered read. The array itself carries no reset.
module frame_fifo_ram
  import mac_rx_frame_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = 512,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  axis_beat_t    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output axis_beat_t    o_rdata
);

  axis_beat_t mem [DEPTH];
  axis_beat_t rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mac_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: accepts every MAC beat, publishes only
// complete good frames, drops bad or oversize frames whole.
module mac_rx_frame_fifo
  import mac_rx_frame_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned W_CNT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clk_en,
  input  logic                 s_axis_tvalid,
  input  logic [N_SYMBOLS-1:0] s_axis_tkeep,
  input  logic [W_DATA-1:0]    s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [N_SYMBOLS-1:0] m_axis_tkeep,
  output logic [W_DATA-1:0]    m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic [W_CNT-1:0]     o_drop_cnt,
  output logic [W_CNT-1:0]     o_ovf_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  wr_state_e         state_q, state_d;
  logic              resync_q, resync_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     wr_commit_q, wr_commit_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [W_CNT-1:0]  drop_cnt_q, drop_cnt_d;
  logic [W_CNT-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic              ram_vld_q, ram_vld_d;
  axis_beat_t        out_q, out_d;
  logic              out_vld_q, out_vld_d;
  axis_beat_t        skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;

  logic       beat_acc;
  logic       full;
  logic       ram_we;
  logic       ram_re;
  logic       drop_inc;
  logic       ovf_inc;
  logic       pop;
  logic [1:0] occ;
  axis_beat_t wr_beat;
  axis_beat_t ram_rdata;

  assign beat_acc = i_clk_en && s_axis_tvalid;
  assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign wr_beat  = '{tlast: s_axis_tlast, tkeep: s_axis_tkeep, tdata: s_axis_tdata};

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= WR_IDLE;
      resync_q    <= 1'b1;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      ovf_cnt_q   <= '0;
      ram_vld_q   <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resync_q    <= resync_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      ram_vld_q   <= ram_vld_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
    end
  end

  // Next state. After reset the input may be mid-frame, so nothing is kept
  // until a tlast has been seen (resync_q).
  always_comb begin
    state_d  = state_q;
    resync_d = resync_q;
    if (beat_acc) begin
      unique case (state_q)
        WR_IDLE: begin
          if (resync_q) begin
            if (s_axis_tlast) resync_d = 1'b0;
            else              state_d  = WR_DROP;
          end else if (!s_axis_tlast) begin
            state_d = full ? WR_DROP : WR_FRAME;
          end
        end
        WR_FRAME: begin
          if (s_axis_tlast) state_d = WR_IDLE;
          else if (full)    state_d = WR_DROP;
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            state_d  = WR_IDLE;
            resync_d = 1'b0;
          end
        end
        default: state_d = WR_IDLE;
      endcase
    end
  end

  // Write-side outputs: RAM write, pointer moves, statistics events
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    ram_we      = 1'b0;
    drop_inc    = 1'b0;
    ovf_inc     = 1'b0;
    if (beat_acc) begin
      unique case (state_q)
        WR_IDLE, WR_FRAME: begin
          if (state_q == WR_IDLE && resync_q) begin
            ram_we = 1'b0;
          end else if (full) begin
            wr_ptr_d = wr_commit_q;
            ovf_inc  = s_axis_tlast;
          end else if (!s_axis_tlast) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
          end else if (!s_axis_tuser) begin
            ram_we      = 1'b1;
            wr_ptr_d    = wr_ptr_q + PW'(1);
            wr_commit_d = wr_ptr_q + PW'(1);
          end else begin
            wr_ptr_d = wr_commit_q;
            drop_inc = 1'b1;
          end
        end
        WR_DROP: ovf_inc = s_axis_tlast && !resync_q;
        default: ram_we = 1'b0;
      endcase
    end
    drop_cnt_d = (drop_inc && drop_cnt_q != '1) ? drop_cnt_q + W_CNT'(1) : drop_cnt_q;
    ovf_cnt_d  = (ovf_inc && ovf_cnt_q != '1) ? ovf_cnt_q + W_CNT'(1) : ovf_cnt_q;
  end

  // Read side. occ counts beats held in out/skid plus the one arriving from
  // the RAM; a read is issued only if its data is sure to find a slot.
  always_comb begin
    pop    = out_vld_q && m_axis_tready;
    occ    = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q);
    ram_re = (rd_ptr_q != wr_commit_q) && (pop ? (occ <= 2'd2) : (occ <= 2'd1));
    rd_ptr_d  = ram_re ? rd_ptr_q + PW'(1) : rd_ptr_q;
    ram_vld_d = ram_re;

    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = ram_vld_q;
        if (ram_vld_q) skid_d = ram_rdata;
      end else if (ram_vld_q) begin
        out_d     = ram_rdata;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (ram_vld_q) begin
      skid_d     = ram_rdata;
      skid_vld_d = 1'b1;
    end
  end

  frame_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (wr_beat),
    .i_re    (ram_re),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (ram_rdata)
  );

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tkeep  = out_q.tkeep;
  assign m_axis_tdata  = out_q.tdata;
  assign m_axis_tlast  = out_q.tlast;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_ovf_cnt     = ovf_cnt_q;

endmodule

// File: tb/tb_mac_rx_frame_fifo.sv
// Bench for mac_rx_frame_fifo: a 16-deep/2-bit-counter instance for directed
// corner cases and a 512-deep instance for the randomised backpressure run.
module tb_mac_rx_frame_fifo;
  import mac_rx_frame_fifo_pkg::*;

  localparam int unsigned DEPTH_S = 16;
  localparam int unsigned WCNT_S  = 2;
  localparam int unsigned DEPTH_L = 512;
  localparam int unsigned WCNT_L  = 16;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, clk_en, s_valid, s_last, s_user, m_ready;
  logic [N_SYMBOLS-1:0] s_keep;
  logic [W_DATA-1:0]    s_data;

  logic                 sm_valid, sm_last, lm_valid, lm_last;
  logic [N_SYMBOLS-1:0] sm_keep, lm_keep;
  logic [W_DATA-1:0]    sm_data, lm_data;
  logic [WCNT_S-1:0]    s_drop, s_ovf;
  logic [WCNT_L-1:0]    l_drop, l_ovf;

  mac_rx_frame_fifo #(.DEPTH(DEPTH_S), .W_CNT(WCNT_S)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en),
    .s_axis_tvalid(s_valid), .s_axis_tkeep(s_keep), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(sm_valid), .m_axis_tready(m_ready), .m_axis_tkeep(sm_keep),
    .m_axis_tdata(sm_data), .m_axis_tlast(sm_last),
    .o_drop_cnt(s_drop), .o_ovf_cnt(s_ovf)
  );

  mac_rx_frame_fifo #(.DEPTH(DEPTH_L), .W_CNT(WCNT_L)) dut_l (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en),
    .s_axis_tvalid(s_valid), .s_axis_tkeep(s_keep), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(lm_valid), .m_axis_tready(m_ready), .m_axis_tkeep(lm_keep),
    .m_axis_tdata(lm_data), .m_axis_tlast(lm_last),
    .o_drop_cnt(l_drop), .o_ovf_cnt(l_ovf)
  );

  typedef struct {
    int          len;
    bit          user;
    logic [7:0]  last_keep;
    bit          kept;
    int          drop;
    int          ovf;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  axis_beat_t exp_q[$];
  bit         sel_large = 1'b0;
  bit         rand_ready = 1'b0;
  bit         en_toggle = 1'b0;
  int         rx_count = 0;
  logic       mon_valid = 1'b0;
  bit         prev_stall = 1'b0;
  axis_beat_t prev_beat;

  function automatic logic [W_DATA-1:0] mk_data(input int fid, input int i);
    return {16'hD0A7, 16'(fid), 32'(i) ^ 32'h5A5A_0000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    axis_beat_t b, e;
    logic       v;
    if (rst) begin
      prev_stall = 1'b0;
      mon_valid  = 1'b0;
      return;
    end
    v = sel_large ? lm_valid : sm_valid;
    b = sel_large ? '{tlast: lm_last, tkeep: lm_keep, tdata: lm_data}
                  : '{tlast: sm_last, tkeep: sm_keep, tdata: sm_data};
    mon_valid = v;
    if (prev_stall) begin
      checks++;
      if (v !== 1'b1 || b !== prev_beat) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b beat=%h expected valid=1 beat=%h", v, b, prev_beat);
      end
    end
    if (v === 1'b1 && m_ready) begin
      checks++;
      rx_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h expected no beat", b);
      end else begin
        e = exp_q.pop_front();
        if (b !== e) begin
          errors++;
          $display("FAIL out_beat: got %h expected %h", b, e);
        end
      end
    end
    prev_stall = (v === 1'b1) && !m_ready;
    prev_beat  = b;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_beat(input logic last, input logic user, input logic [7:0] keep,
                            input logic [W_DATA-1:0] data);
    s_valid = 1'b1;
    s_last  = last;
    s_user  = user;
    s_keep  = keep;
    s_data  = data;
    if (en_toggle) begin
      clk_en = 1'b0;
      tick();
    end
    clk_en = 1'b1;
    tick();
    s_valid = 1'b0;
    clk_en  = 1'b0;
  endtask

  task automatic send_frame(input int fid, input int len, input bit user,
                            input logic [7:0] last_keep, input bit keep_it);
    axis_beat_t b;
    for (int i = 0; i < len; i++) begin
      b.tlast = (i == len - 1);
      b.tkeep = b.tlast ? last_keep : 8'hFF;
      b.tdata = mk_data(fid, i);
      if (keep_it) exp_q.push_back(b);
      // tuser is noise on non-last beats and must be ignored there
      drive_beat(b.tlast, b.tlast ? user : logic'(i % 3 == 1), b.tkeep, b.tdata);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    clk_en  = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic flush();
    drive_beat(1'b1, 1'b0, 8'hFF, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   rx0, nbad;
    vecs[0] = '{len: 8,  user: 1'b0, last_keep: 8'h0F, kept: 1'b1, drop: 0, ovf: 0};
    vecs[1] = '{len: 5,  user: 1'b1, last_keep: 8'hFF, kept: 1'b0, drop: 1, ovf: 0};
    vecs[2] = '{len: 3,  user: 1'b0, last_keep: 8'h01, kept: 1'b1, drop: 1, ovf: 0};
    vecs[3] = '{len: 1,  user: 1'b0, last_keep: 8'h80, kept: 1'b1, drop: 1, ovf: 0};
    vecs[4] = '{len: 1,  user: 1'b1, last_keep: 8'hFF, kept: 1'b0, drop: 2, ovf: 0};
    vecs[5] = '{len: 16, user: 1'b0, last_keep: 8'hFF, kept: 1'b1, drop: 2, ovf: 0};
    vecs[6] = '{len: 17, user: 1'b0, last_keep: 8'hFF, kept: 1'b0, drop: 2, ovf: 1};

    rst = 1'b1; clk_en = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
    s_keep = '0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(sm_valid), 64'd0);
    check("reset_data", sm_data, 64'd0);
    check("reset_keep_last", {55'd0, sm_keep, sm_last}, 64'd0);
    check("reset_cnts", {60'd0, s_drop, s_ovf}, 64'd0);
    do_reset();
    flush();

    for (int i = 0; i < 7; i++) begin
      send_frame(100 + i, vecs[i].len, vecs[i].user, vecs[i].last_keep, vecs[i].kept);
      wait_drain($sformatf("vec%0d_drain", i), 200);
      check($sformatf("vec%0d_drop", i), 64'(s_drop), 64'(vecs[i].drop));
      check($sformatf("vec%0d_ovf", i), 64'(s_ovf), 64'(vecs[i].ovf));
    end

    // Commit-to-valid latency and back-to-back streaming
    do_reset();
    flush();
    rx0 = rx_count;
    send_frame(200, 8, 1'b0, 8'h0F, 1'b1);
    tick(); check("lat_cycle1", 64'(mon_valid), 64'd0);
    tick(); check("lat_cycle2", 64'(mon_valid), 64'd0);
    tick(); check("lat_cycle3", 64'(mon_valid), 64'd1);
    check("stream_first", 64'(rx_count - rx0), 64'd1);
    repeat (7) tick();
    check("stream_rate", 64'(rx_count - rx0), 64'd8);
    wait_drain("lat_drain", 50);

    // Overflow with the output stalled
    do_reset();
    flush();
    m_ready = 1'b0;
    send_frame(300, 10, 1'b0, 8'hFF, 1'b1);
    send_frame(301, 10, 1'b0, 8'hFF, 1'b0);
    repeat (4) tick();
    check("ovf_second", 64'(s_ovf), 64'd1);
    check("ovf_held_valid", 64'(mon_valid), 64'd1);
    rx0 = rx_count;
    m_ready = 1'b1;
    wait_drain("ovf_drain", 100);
    check("ovf_beats_out", 64'(rx_count - rx0), 64'd10);
    send_frame(302, 20, 1'b0, 8'hFF, 1'b0);
    repeat (4) tick();
    check("ovf_long", 64'(s_ovf), 64'd2);
    check("ovf_no_drop", 64'(s_drop), 64'd0);
    check("ovf_no_output", 64'(rx_count - rx0), 64'd10);

    // Reset in the middle of a frame, with a buffered frame stalled
    do_reset();
    flush();
    m_ready = 1'b0;
    send_frame(399, 3, 1'b0, 8'hFF, 1'b1);
    drive_beat(1'b0, 1'b0, 8'hFF, mk_data(400, 0));
    drive_beat(1'b0, 1'b0, 8'hFF, mk_data(400, 1));
    check("pre_reset_valid", 64'(sm_valid), 64'd1);
    s_valid = 1'b1; clk_en = 1'b1; s_last = 1'b0; s_data = mk_data(400, 2);
    rst = 1'b1;
    exp_q.delete();
    #2;
    check("mid_reset_valid", 64'(sm_valid), 64'd0);
    check("mid_reset_data", sm_data, 64'd0);
    check("mid_reset_keep_last", {55'd0, sm_keep, sm_last}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    drive_beat(1'b0, 1'b0, 8'hFF, mk_data(400, 3));
    drive_beat(1'b0, 1'b0, 8'hFF, mk_data(400, 4));
    drive_beat(1'b1, 1'b0, 8'hFF, mk_data(400, 5));
    send_frame(401, 4, 1'b0, 8'h0F, 1'b1);
    wait_drain("rst_drain", 100);
    check("rst_drop", 64'(s_drop), 64'd0);

    // Drop counter saturation on the 2-bit instance
    do_reset();
    flush();
    for (int k = 0; k < 5; k++) begin
      send_frame(500 + k, 2, 1'b1, 8'hFF, 1'b0);
      check($sformatf("sat_drop%0d", k), 64'(s_drop), (k < 3) ? 64'(k + 1) : 64'd3);
    end

    // Randomised backpressure and clock-enable gaps on the deep instance
    sel_large = 1'b1;
    do_reset();
    flush();
    en_toggle  = 1'b1;
    rand_ready = 1'b1;
    nbad = 0;
    for (int f = 0; f < 50; f++) begin
      int         len;
      bit         bad;
      logic [7:0] lk;
      len = int'($urandom_range(1, 64));
      bad = ($urandom_range(0, 4) == 0);
      lk  = 8'($urandom_range(1, 255));
      send_frame(600 + f, len, bad, lk, !bad);
      if (bad) nbad++;
    end
    wait_drain("rand_drain", 20000);
    check("rand_drop", 64'(l_drop), 64'(nbad));
    check("rand_ovf", 64'(l_ovf), 64'd0);
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_rx_frame_fifo.md
Name: mac_rx_frame_fifo

Overview:
- Store-and-forward receive buffer directly downstream of the MAC RX AXI-Stream master. The MAC RX output has no tready.
- Accepts every beat the MAC RX produces. Keeps a frame only if it ends with tuser=0, so frames flagged bad (FCS or framing error) are discarded.
- Presents only complete, good frames on an AXI-Stream master with full backpressure toward the user/application side.
- Frames that do not fit are dropped whole, never truncated.

Parameters:
- DEPTH, 512, buffer entries (beats); power of two, at least 16.
- W_CNT, 16, width of the drop/overflow statistics counters.
- Beat geometry uses the shared package constants N_SYMBOLS and W_SYMBOL.

Ports:
- i_clk  in  1  single clock, shared with the MAC.
- i_reset  in  1  asynchronous reset, active-high; clears all state.
- i_clk_en  in  1  input-side beat qualifier (the MAC RX clock enable).
- s_axis_tvalid  in  1  beat valid from MAC RX.
- s_axis_tkeep  in  N_SYMBOLS  byte enables.
- s_axis_tdata  in  N_SYMBOLS*W_SYMBOL  beat data.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  frame-bad flag; meaningful only with tlast.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tkeep  out  N_SYMBOLS  byte enables.
- m_axis_tdata  out  N_SYMBOLS*W_SYMBOL  beat data.
- m_axis_tlast  out  1  last beat of frame.
- o_drop_cnt  out  W_CNT  count of frames dropped for tuser=1.
- o_ovf_cnt  out  W_CNT  count of frames dropped for overflow.

Behaviour:
- Write acceptance: a beat is written when i_clk_en && s_axis_tvalid. There is no input backpressure.
- Stored entry: {tlast, tkeep, tdata}, written verbatim.
- Pointers: wr_ptr, wr_commit and rd_ptr, each log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
  - full: (wr_ptr - rd_ptr) == DEPTH.
  - committed data available: rd_ptr != wr_commit.
- Write FSM states:
  - IDLE:
    - Accepted beat, not full: write it; go to FRAME, or to the end-of-frame handling below if it carries tlast.
    - Accepted beat while full: go to DROP.
  - FRAME, accepted beat with full=1: rewind wr_ptr to wr_commit and go to DROP; o_ovf_cnt+1 on the beat that ends the frame.
  - FRAME, end of frame (beat with tlast):
    - tuser=0: write the beat, then wr_commit <= wr_ptr+1 (the frame becomes readable).
    - tuser=1: wr_ptr <= wr_commit; o_drop_cnt+1.
    - Either way, return to IDLE.
  - DROP: discard every beat until and including tlast; o_ovf_cnt+1 on that tlast beat; return to IDLE.
  - A single-beat frame (tlast on the first beat) follows the same rules starting from IDLE.
- Frames longer than DEPTH beats always overflow.
- Read side:
  - RAM read latency 1 cycle; registered output stage with a 2-entry skid.
  - m_axis_* change only when !(m_axis_tvalid && !m_axis_tready).
  - AXI-Stream rules hold: once asserted, tvalid stays high and data stays stable until the transfer.
- Latency: with the output empty and tready=1, m_axis_tvalid first rises exactly 2 cycles after the edge that commits the frame. Back-to-back beats then stream at 1 beat/cycle.
- Simultaneous write and read in the same cycle are legal. full is evaluated on pre-edge pointers, so a slot freed by a read becomes usable the following cycle.
- Counters saturate at all-ones.
- Reset values:
  - m_axis_tvalid=0, m_axis_tkeep=0, m_axis_tdata=0, m_axis_tlast=0.
  - o_drop_cnt=0, o_ovf_cnt=0.
  - All pointers 0; FSM in IDLE.
  - Reset mid-frame discards partial and buffered frames. Beats of a frame already in flight on the input are dropped: the FSM enters DROP if the first beat seen after reset does not start a new frame. A frame start is not observable, so the block resumes writing only after the next tlast.
- Output is never written for dropped frames; no partial frame is ever visible.

Decomposition:
- Shared package: N_SYMBOLS, W_SYMBOL, an axis_beat_t struct {tlast, tkeep, tdata}, and the write-FSM state enum.
- One sub-module: frame_fifo_ram, a simple dual-port RAM, DEPTH x $bits(axis_beat_t), 1-cycle registered read, inferred memory, no reset on the array.

Test Plan:
- Good frame: 8-beat frame, tuser=0, last tkeep=8'h0F, tready=1 -> identical 8 beats out, first valid 2 cycles after commit; o_drop_cnt=0.
- Bad frame: 5-beat frame, tuser=1, followed by a 3-beat good frame -> only the 3-beat frame appears; o_drop_cnt=1.
- Overflow: DEPTH=16, tready=0, 10-beat frame, then a 10-beat frame -> first frame kept, second dropped; o_ovf_cnt=1; after tready=1 exactly 10 beats out. A 20-beat frame -> dropped, o_ovf_cnt=2.
- Backpressure: random tready (50%) over 50 frames of 1-64 beats with i_clk_en toggling -> output sequence equals input good frames; tvalid/tdata stable while stalled.
- Reset mid-frame: assert i_reset during beat 3 of a 6-beat frame, release, send a new 4-beat frame -> outputs 0 during reset; beats 4-6 dropped (DROP until tlast); only the 4-beat frame is output.
- Counter saturation: W_CNT=2, 5 bad frames -> o_drop_cnt holds at 3.
